nn_launch_controller: RTL and testbench
=======================================

# nn_launch_controller

Launch sequencer between the MNIST drawing grid and the neural network core. It synchronizes and debounces the raw active-low launch button, then snapshots the 784-bit drawn image into a stable buffer. It issues a one-cycle start pulse to the network, then captures the argmax class on done. The captured class feeds the seven-segment decoder, so the network never sees pixels change mid-inference.

## Interface
- DEBOUNCE_CYCLES, 1000: consecutive pressed cycles required before launch; must be ≥1.
- TIMEOUT_CYCLES, 65535: WAIT-state cycles before a timeout is flagged; used only with NN_LAUNCH_TIMEOUT_EN.
- clk  in  1  single clock; this block and the neural network share it.
- reset  in  1  synchronous, active-high reset.
- key_n  in  1  raw asynchronous push-button, active low.
- pixel_in  in  784  live pixel memory from the drawing grid.
- nn_done  in  1  done from the network, level or pulse.
- nn_argmax  in  4  class index from the network.
- nn_start  out  1  one-cycle launch pulse to the network.
- pixel_out  out  784  frozen image driven to the network's pixel_data.
- busy  out  1  high in LAUNCH and WAIT.
- result_valid  out  1  result holds a class from a completed inference.
- result  out  4  latched class.
- timeout_err  out  1  last launch timed out.
- launch_count  out  8  completed inferences, saturating.

## Operation
- key_n passes through a 2-flop synchronizer; pressed = synchronized value is 0.
- States: IDLE, DEBOUNCE, LAUNCH, WAIT, RELEASE.
- IDLE: on pressed, go to DEBOUNCE and clear deb_cnt.
- DEBOUNCE:
  - Released: return to IDLE.
  - deb_cnt == DEBOUNCE_CYCLES-1: go to LAUNCH and load pixel_out <= pixel_in on the same edge.
  - Otherwise deb_cnt++.
- LAUNCH: nn_start=1 for this state only; clear result_valid and timeout_err; clear wait_cnt. Always go to WAIT.
- WAIT:
  - nn_done=1: result <= nn_argmax, result_valid <= 1, launch_count <= min(count+1, 255), go to RELEASE.
  - Timeout (macro on): wait_cnt == TIMEOUT_CYCLES-1 with no done sets timeout_err <= 1, go to RELEASE; result and result_valid stay unchanged (valid stays 0).
- RELEASE: stay until the synchronized key reads released, then go to IDLE. This blocks auto-relaunch while the key is held.
- nn_done outside WAIT is ignored, including the LAUNCH cycle.
- Key activity during LAUNCH and WAIT is ignored.
- pixel_out changes only on the DEBOUNCE→LAUNCH edge.
- deb_cnt is sized $clog2(DEBOUNCE_CYCLES)+1 bits; wait_cnt is $clog2(TIMEOUT_CYCLES)+1 bits. Neither wraps: each is cleared on state entry.

## Timing
- Reset values: state IDLE, nn_start 0, pixel_out all-0, busy 0, result_valid 0, result 4'h0, timeout_err 0, launch_count 0, synchronizer flops 1 (released).
- Reset mid-operation: all outputs return to reset values on the next edge. Any in-flight inference result is discarded.
- Launch latency: let e0 be the first edge sampling key_n=0, with the key held. DEBOUNCE is entered at e2, and LAUNCH at e(2+DEBOUNCE_CYCLES). nn_start is high during the cycle following that edge, exactly 1 cycle wide.
- Result latency: result and result_valid update on the first edge in WAIT that samples nn_done=1. The minimum is 2 cycles after the nn_start rise.
- All outputs are registered (Moore); no input-to-output combinational path.

## Configuration
- NN_LAUNCH_TIMEOUT_EN defined: wait_cnt and the timeout exit exist, and timeout_err behaves as above.
- Not defined: WAIT exits only on nn_done; wait_cnt is not synthesized; timeout_err is tied to 0; TIMEOUT_CYCLES is unused.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16.
- Clean press: key_n held low, pixel_in=pattern A, nn_done pulsed with nn_argmax=7 three cycles after nn_start.
  - nn_start is a single pulse at e6.
  - pixel_out=A.
  - result=7, result_valid=1, launch_count=1.
- Bounce: key_n low for 3 cycles, high, then low again for 3 cycles → state never reaches LAUNCH and nn_start stays 0.
- Snapshot stability: pixel_in changes to B while busy → pixel_out stays A until the next launch. Holding the key after done does not relaunch; release then press again → second launch with pixel_out=B and launch_count=2.
- Timeout (macro on): no nn_done → timeout_err=1 exactly 16 WAIT cycles after entry; result_valid=0. The next launch clears timeout_err. With the macro off, the block stays in WAIT indefinitely with timeout_err=0.
- Reset mid-WAIT: assert reset for one cycle, then drive nn_done=1 → all outputs are at reset values, nn_done is ignored, and launch_count stays 0.
- Saturation: 260 completed launches → launch_count=255.

Source files
------------

// File: rtl/nn_launch_controller.sv
// Launch sequencer: debounces the active-low key, freezes the drawn image, pulses nn_start
// and latches the network's argmax. Optional WAIT timeout under macro NN_LAUNCH_TIMEOUT_EN.
module nn_launch_controller #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_n,
    input  logic [783:0] pixel_in,
    input  logic         nn_done,
    input  logic [3:0]   nn_argmax,
    output logic         nn_start,
    output logic [783:0] pixel_out,
    output logic         busy,
    output logic         result_valid,
    output logic [3:0]   result,
    output logic         timeout_err,
    output logic [7:0]   launch_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    // Both parameters must describe at least one cycle.
    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("nn_launch_controller: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        LAUNCH   = 3'd2,
        WAIT     = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    state_t         state_q;
    logic [1:0]     sync_q;
    logic [DW-1:0]  deb_cnt_q;
    logic           nn_start_q;
    logic [783:0]   pixel_q;
    logic           busy_q;
    logic           result_valid_q;
    logic [3:0]     result_q;
    logic [7:0]     launch_count_q;
    logic           pressed;

    assign pressed = ~sync_q[1];

`ifdef NN_LAUNCH_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0]  wait_cnt_q;
    logic           timeout_err_q;
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sync_q         <= 2'b11;
            deb_cnt_q      <= '0;
            nn_start_q     <= 1'b0;
            pixel_q        <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= 4'h0;
            launch_count_q <= 8'd0;
`ifdef NN_LAUNCH_TIMEOUT_EN
            wait_cnt_q     <= '0;
            timeout_err_q  <= 1'b0;
`endif
        end else begin
            sync_q     <= {sync_q[0], key_n};
            nn_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pressed) begin
                        state_q   <= DEBOUNCE;
                        deb_cnt_q <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (!pressed) begin
                        state_q <= IDLE;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        // The snapshot is taken on the same edge that raises nn_start.
                        state_q    <= LAUNCH;
                        pixel_q    <= pixel_in;
                        nn_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end
                LAUNCH: begin
                    state_q        <= WAIT;
                    result_valid_q <= 1'b0;
`ifdef NN_LAUNCH_TIMEOUT_EN
                    timeout_err_q  <= 1'b0;
                    wait_cnt_q     <= '0;
`endif
                end
                WAIT: begin
                    if (nn_done) begin
                        state_q        <= RELEASE;
                        busy_q         <= 1'b0;
                        result_q       <= nn_argmax;
                        result_valid_q <= 1'b1;
                        if (launch_count_q != 8'hFF) begin
                            launch_count_q <= launch_count_q + 8'd1;
                        end
`ifdef NN_LAUNCH_TIMEOUT_EN
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q       <= RELEASE;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    // Holding the key after a result must not relaunch.
                    if (!pressed) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign nn_start     = nn_start_q;
    assign pixel_out    = pixel_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign launch_count = launch_count_q;

endmodule

// File: tb/tb_nn_launch_controller.sv
// Directed self-checking bench for nn_launch_controller (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_nn_launch_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_n;
    logic [783:0] pixel_in;
    logic         nn_done;
    logic [3:0]   nn_argmax;
    logic         nn_start;
    logic [783:0] pixel_out;
    logic         busy;
    logic         result_valid;
    logic [3:0]   result;
    logic         timeout_err;
    logic [7:0]   launch_count;

    int checks = 0;
    int failures = 0;

    logic [783:0] pat_a;
    logic [783:0] pat_b;

    nn_launch_controller #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_n),
        .pixel_in    (pixel_in),
        .nn_done     (nn_done),
        .nn_argmax   (nn_argmax),
        .nn_start    (nn_start),
        .pixel_out   (pixel_out),
        .busy        (busy),
        .result_valid(result_valid),
        .result      (result),
        .timeout_err (timeout_err),
        .launch_count(launch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [783:0] got, input logic [783:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press and hold the key through edges e0..e6; returns pulse count and last pulse edge.
    task automatic press_to_launch(output int pulses, output int pulse_edge);
        pulses = 0;
        pulse_edge = -1;
        key_n = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            tick();
            if (nn_start) begin
                pulses++;
                pulse_edge = k;
            end
        end
    endtask

    task automatic release_key();
        key_n = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        int pulses;
        int pedge;

        pat_a = {49{16'hA5C3}};
        pat_b = {49{16'h3C5A}};
        reset = 1'b1;
        key_n = 1'b1;
        pixel_in = pat_a;
        nn_done = 1'b0;
        nn_argmax = 4'h0;
        repeat (3) tick();

        check("rst_nn_start", 784'(nn_start), 784'(1'b0));
        check("rst_pixel_out", pixel_out, '0);
        check("rst_busy", 784'(busy), 784'(1'b0));
        check("rst_valid", 784'(result_valid), 784'(1'b0));
        check("rst_result", 784'(result), 784'(4'h0));
        check("rst_timeout", 784'(timeout_err), 784'(1'b0));
        check("rst_count", 784'(launch_count), 784'(8'd0));
        reset = 1'b0;
        repeat (2) tick();

        // Clean press: single nn_start pulse after e6.
        press_to_launch(pulses, pedge);
        check("clean_pulses", 784'(pulses), 784'(1));
        check("clean_pulse_edge", 784'(pedge), 784'(6));
        check("clean_busy", 784'(busy), 784'(1'b1));
        check("clean_pixel_out", pixel_out, pat_a);
        tick();
        check("clean_start_width", 784'(nn_start), 784'(1'b0));
        tick();
        nn_done = 1'b1;
        nn_argmax = 4'd7;
        pixel_in = pat_b;
        tick();
        nn_done = 1'b0;
        check("clean_result", 784'(result), 784'(4'd7));
        check("clean_valid", 784'(result_valid), 784'(1'b1));
        check("clean_count", 784'(launch_count), 784'(8'd1));
        check("clean_busy_done", 784'(busy), 784'(1'b0));
        check("snap_hold_a", pixel_out, pat_a);

        // Key still held: no relaunch.
        pulses = 0;
        repeat (20) begin
            tick();
            if (nn_start) pulses++;
        end
        check("hold_no_relaunch", 784'(pulses), 784'(0));
        release_key();

        // Second launch picks up the new image.
        press_to_launch(pulses, pedge);
        check("second_pulse_edge", 784'(pedge), 784'(6));
        check("second_pixel_out", pixel_out, pat_b);
        tick();
        tick();
        nn_done = 1'b1;
        nn_argmax = 4'd3;
        tick();
        nn_done = 1'b0;
        check("second_result", 784'(result), 784'(4'd3));
        check("second_count", 784'(launch_count), 784'(8'd2));
        release_key();

        // Bounce: 3 low, 1 high, 3 low never reaches LAUNCH.
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            key_n = (k == 3 || k >= 7) ? 1'b1 : 1'b0;
            tick();
            if (nn_start || busy) pulses++;
        end
        check("bounce_no_launch", 784'(pulses), 784'(0));
        check("bounce_count", 784'(launch_count), 784'(8'd2));

        // Timeout behaviour.
        press_to_launch(pulses, pedge);
        tick();
`ifdef NN_LAUNCH_TIMEOUT_EN
        check("to_cleared_entry", 784'(timeout_err), 784'(1'b0));
        repeat (15) tick();
        check("to_not_yet", 784'(timeout_err), 784'(1'b0));
        check("to_busy_15", 784'(busy), 784'(1'b1));
        tick();
        check("to_flag", 784'(timeout_err), 784'(1'b1));
        check("to_valid", 784'(result_valid), 784'(1'b0));
        check("to_result_kept", 784'(result), 784'(4'd3));
        check("to_busy_off", 784'(busy), 784'(1'b0));
        release_key();
        press_to_launch(pulses, pedge);
        tick();
        check("to_cleared_next", 784'(timeout_err), 784'(1'b0));
`else
        repeat (40) tick();
        check("noto_busy", 784'(busy), 784'(1'b1));
        check("noto_timeout", 784'(timeout_err), 784'(1'b0));
        check("noto_valid", 784'(result_valid), 784'(1'b0));
`endif
        nn_done = 1'b1;
        nn_argmax = 4'd5;
        tick();
        nn_done = 1'b0;
        check("to_done_result", 784'(result), 784'(4'd5));
        release_key();

        // Reset mid-WAIT discards the in-flight inference.
        press_to_launch(pulses, pedge);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nn_done = 1'b1;
        nn_argmax = 4'd9;
        tick();
        nn_done = 1'b0;
        check("mid_rst_busy", 784'(busy), 784'(1'b0));
        check("mid_rst_valid", 784'(result_valid), 784'(1'b0));
        check("mid_rst_result", 784'(result), 784'(4'h0));
        check("mid_rst_count", 784'(launch_count), 784'(8'd0));
        check("mid_rst_pixel", pixel_out, '0);
        check("mid_rst_start", 784'(nn_start), 784'(1'b0));
        release_key();

        // Saturation over 260 completed launches.
        for (int n = 1; n <= 260; n++) begin
            press_to_launch(pulses, pedge);
            tick();
            nn_done = 1'b1;
            nn_argmax = 4'(n % 10);
            tick();
            nn_done = 1'b0;
            release_key();
            if (n == 255) check("sat_count_255", 784'(launch_count), 784'(8'd255));
        end
        check("sat_count_260", 784'(launch_count), 784'(8'd255));
        check("sat_result", 784'(result), 784'(4'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
